// File: rtl/mac_array_ctrl.sv
// Job sequencer for the weight-stationary MAC array. It loads one weight word per row,
// streams the input vectors with compute enabled, waits for the pipeline to drain, then pulses done.
module mac_array_ctrl #(
  parameter int ROWS             = 4,
  parameter int COLS             = 4,
  parameter int INPUT_DATA_WIDTH = 4,
  parameter int VEC_CNT_WIDTH    = 8,
  parameter int DRAIN_CYCLES     = ROWS + COLS - 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [VEC_CNT_WIDTH-1:0]          num_vectors,
  output logic                              busy,
  output logic                              done,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [COLS*INPUT_DATA_WIDTH-1:0]  w_data,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [COLS*INPUT_DATA_WIDTH-1:0]  x_data,
  output logic                              acc_clr,
  output logic [ROWS-1:0]                   load_en,
  output logic                              compute,
  output logic [COLS*INPUT_DATA_WIDTH-1:0]  arr_data
);

  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                   state_reg, state_next;
  logic [RW-1:0]            row_cnt_reg, row_cnt_next;
  logic [VEC_CNT_WIDTH-1:0] vec_cnt_reg, vec_cnt_next;
  logic [VEC_CNT_WIDTH-1:0] num_reg, num_next;
  logic [DCW-1:0]           drain_cnt_reg, drain_cnt_next;
  logic                     first_reg, first_next;
  logic                     w_xfer, x_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      row_cnt_reg   <= '0;
      vec_cnt_reg   <= '0;
      num_reg       <= '0;
      drain_cnt_reg <= '0;
      first_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_cnt_reg   <= row_cnt_next;
      vec_cnt_reg   <= vec_cnt_next;
      num_reg       <= num_next;
      drain_cnt_reg <= drain_cnt_next;
      first_reg     <= first_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    row_cnt_next   = row_cnt_reg;
    vec_cnt_next   = vec_cnt_reg;
    num_next       = num_reg;
    drain_cnt_next = drain_cnt_reg;
    first_next     = 1'b0;
    busy           = (state_reg != S_IDLE);
    done           = 1'b0;
    w_ready        = 1'b0;
    x_ready        = 1'b0;
    acc_clr        = 1'b0;
    compute        = 1'b0;
    w_xfer         = 1'b0;
    x_xfer         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          num_next     = num_vectors;
          row_cnt_next = '0;
          vec_cnt_next = '0;
          first_next   = 1'b1;
          state_next   = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        // first_reg marks only the entry cycle, so stalls on row 0 do not re-clear
        acc_clr = first_reg;
        w_ready = 1'b1;
        w_xfer  = w_valid;
        if (w_valid) begin
          if (row_cnt_reg == RW'(ROWS - 1)) begin
            state_next = (num_reg == '0) ? S_DONE : S_COMPUTE;
          end else begin
            row_cnt_next = row_cnt_reg + RW'(1);
          end
        end
      end
      S_COMPUTE: begin
        x_ready = 1'b1;
        compute = x_valid;
        x_xfer  = x_valid;
        if (x_valid) begin
          vec_cnt_next = vec_cnt_reg + VEC_CNT_WIDTH'(1);
          if (vec_cnt_reg == num_reg - VEC_CNT_WIDTH'(1)) begin
            drain_cnt_next = '0;
            state_next     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == DCW'(DRAIN_CYCLES - 1)) begin
          state_next = S_DONE;
        end else begin
          drain_cnt_next = drain_cnt_reg + DCW'(1);
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_load_en
      assign load_en[gi] = w_xfer && (row_cnt_reg == RW'(gi));
    end
  endgenerate

  assign arr_data = w_xfer ? w_data : (x_xfer ? x_data : '0);

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Testbench for mac_array_ctrl. A model predicts the transfer timeline of each job from the
// valid patterns it drives. Outputs are compared against that prediction on every cycle.
module tb_mac_array_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int IDW   = 4;
  localparam int VCW   = 8;
  localparam int DRAIN = ROWS + COLS - 1;
  localparam int DW    = COLS * IDW;
  localparam int N     = 1024;
  localparam int OW    = 5 + ROWS + 1 + DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [VCW-1:0]  num_vectors;
  logic            busy, done, w_valid, w_ready, x_valid, x_ready;
  logic [DW-1:0]   w_data, x_data, arr_data;
  logic            acc_clr, compute;
  logic [ROWS-1:0] load_en;

  mac_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .INPUT_DATA_WIDTH(IDW), .VEC_CNT_WIDTH(VCW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .acc_clr(acc_clr),
    .load_en(load_en), .compute(compute), .arr_data(arr_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic          wv[N];
  logic          xv[N];
  logic [DW-1:0] wd[N];
  logic [DW-1:0] xd[N];

  logic [OW-1:0] obs_w;
  assign obs_w = {busy, done, w_ready, x_ready, acc_clr, load_en, compute, arr_data};

  task automatic check(input string tag, input int c, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
  endtask

  task automatic fill(input int wp, input int xp);
    for (int c = 0; c < N; c++) begin
      wv[c] = ($urandom_range(99) < wp);
      xv[c] = ($urandom_range(99) < xp);
      wd[c] = DW'($urandom);
      xd[c] = DW'($urandom);
    end
  endtask

  // Model: loads are the first ROWS w_valid cycles after start; computes are the first num
  // x_valid cycles after the last load; done follows the last compute after the drain.
  task automatic run_job(input string tag, input int num, input bit busy_start);
    int load_c[ROWS];
    int k, last_load, last_comp, done_c, extra1, extra2;
    int loads_seen, comps_seen, dones_seen;
    logic [ROWS-1:0] e_load;
    logic [DW-1:0]   e_data;
    logic e_busy, e_done, e_wr, e_xr, e_clr, e_comp;
    k = 0; last_comp = 0;
    for (int c = 1; c < N && k < ROWS; c++) if (wv[c]) begin load_c[k] = c; k++; end
    if (k < ROWS) begin
      total++; $error("FAIL %s_model observed=%0d loads expected=%0d", tag, k, ROWS); return;
    end
    last_load = load_c[ROWS-1];
    if (num == 0) done_c = last_load + 1;
    else begin
      k = 0;
      for (int c = last_load + 1; c < N && k < num; c++) if (xv[c]) begin k++; last_comp = c; end
      if (k < num) begin
        total++; $error("FAIL %s_model observed=%0d vectors expected=%0d", tag, k, num); return;
      end
      done_c = last_comp + DRAIN + 1;
    end
    if (done_c + 2 >= N) begin
      total++; $error("FAIL %s_model observed=%0d cycles expected=<%0d", tag, done_c, N); return;
    end
    extra1 = busy_start ? last_load + 2 : -1;
    extra2 = busy_start ? done_c : -1;
    loads_seen = 0; comps_seen = 0; dones_seen = 0;
    for (int c = 0; c <= done_c + 1; c++) begin
      start       = (c == 0) || (c == extra1) || (c == extra2);
      num_vectors = (c == 0) ? VCW'(num) : VCW'($urandom);
      w_valid = wv[c]; w_data = wd[c];
      x_valid = xv[c]; x_data = xd[c];
      e_busy = (c >= 1) && (c <= done_c);
      e_done = (c == done_c);
      e_wr   = (c >= 1) && (c <= last_load);
      e_xr   = (num != 0) && (c > last_load) && (c <= last_comp);
      e_clr  = (c == 1);
      e_load = '0;
      for (int r = 0; r < ROWS; r++) if (load_c[r] == c) e_load[r] = 1'b1;
      e_comp = e_xr && xv[c];
      e_data = (e_load != '0) ? wd[c] : (e_comp ? xd[c] : '0);
      @(negedge clk);
      check(tag, c, obs_w, {e_busy, e_done, e_wr, e_xr, e_clr, e_load, e_comp, e_data});
      if (load_en != '0) loads_seen++;
      if (compute) comps_seen++;
      if (done) dones_seen++;
      @(posedge clk); #1;
    end
    start = 1'b0; w_valid = 1'b0; x_valid = 1'b0;
    check({tag, "_loads"}, done_c, OW'(loads_seen), OW'(ROWS));
    check({tag, "_computes"}, done_c, OW'(comps_seen), OW'(num));
    check({tag, "_dones"}, done_c, OW'(dones_seen), OW'(1));
    $display("job %s: num=%0d done_cycle=%0d loads=%0d computes=%0d", tag, num, done_c, loads_seen, comps_seen);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_vectors = '0;
    w_valid = 1'b0; x_valid = 1'b0; w_data = '0; x_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", 0, obs_w, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic job, valids held high
    fill(100, 100);
    run_job("basic", 3, 1'b0);

    // w_valid toggling, two idle x cycles mid-stream
    fill(100, 100);
    for (int c = 0; c < N; c++) wv[c] = c[0];
    xv[9] = 1'b0; xv[10] = 1'b0;
    run_job("stalls", 3, 1'b0);

    fill(100, 100);
    run_job("zero_vec", 0, 1'b0);

    fill(100, 100);
    run_job("busy_start", 5, 1'b1);

    // abort mid-COMPUTE after one vector has been accepted
    start = 1'b1; num_vectors = 8'd3; w_valid = 1'b1; x_valid = 1'b1;
    w_data = DW'($urandom); x_data = DW'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(posedge clk); #3;
    check("pre_abort_compute", 6, OW'(compute), OW'(1));
    rst_n = 1'b0; #1;
    check("abort_outputs", 6, obs_w, '0);
    @(negedge clk);
    check("abort_hold", 6, obs_w, '0);
    rst_n = 1'b1; w_valid = 1'b0; x_valid = 1'b0;
    @(posedge clk); #1;
    fill(100, 100);
    run_job("after_abort", 3, 1'b0);

    for (int j = 0; j < 4; j++) begin
      fill(40 + 15 * j, 50 + 10 * j);
      run_job("random", $urandom_range(12, 0), j[0]);
    end

    fill(100, 100);
    run_job("max_count", 255, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
